// File: rtl/counter_pkg.sv
// Shared CPU constants used by the timer/tick counter.
//   COUNTER_WIDTH : default counter width in bits
//   DATA_WIDTH    : CPU data-bus width in bits
package counter_pkg;

    localparam int DATA_WIDTH    = 16;
    localparam int COUNTER_WIDTH = 16;

endpackage

// File: rtl/counter.sv
// Loadable free-running up-counter with a one-cycle overflow pulse.
// Serves as the CPU general timer/tick source.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset, clears value and overflow
//   en       in   count enable, value increments on each enabled edge
//   we       in   write enable, loads data (takes priority over en)
//   data     in   parallel load value
//   value    out  current count (registered)
//   overflow out  one-cycle pulse after the edge that wraps all-ones to zero
module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] value,
    output logic             overflow
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value    <= '0;
            overflow <= 1'b0;
        end else if (we) begin
            // A load never flags overflow, even when it lands on zero.
            value    <= data;
            overflow <= 1'b0;
        end else if (en) begin
            value    <= value + 1'b1;
            overflow <= &value;
        end else begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_counter.sv
module tb_counter;

    typedef struct {
        logic        rst;
        logic        we;
        logic        en;
        logic [15:0] data;
        logic [15:0] exp_value;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        we;
    logic [15:0] data;
    logic [15:0] value;
    logic        overflow;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t tv [27];

    counter #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .we       (we),
        .data     (data),
        .value    (value),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] ev, input logic eo);
        n_vec++;
        if (value !== ev || overflow !== eo) begin
            n_miss++;
            $display("FAIL %s: value=%h overflow=%b, expected value=%h overflow=%b",
                     name, value, overflow, ev, eo);
        end
    endtask

    task automatic set_v(input int i, input logic r, input logic w, input logic e,
                         input logic [15:0] d, input logic [15:0] ev, input logic eo);
        tv[i].rst       = r;
        tv[i].we        = w;
        tv[i].en        = e;
        tv[i].data      = d;
        tv[i].exp_value = ev;
        tv[i].exp_ovf   = eo;
    endtask

    // Drive on the falling edge, check 1 time unit after the rising edge.
    task automatic run(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            @(negedge clk);
            rst  = tv[i].rst;
            we   = tv[i].we;
            en   = tv[i].en;
            data = tv[i].data;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), tv[i].exp_value, tv[i].exp_ovf);
        end
    endtask

    // Pulse reset between edges and check the outputs clear before any edge.
    task automatic async_reset(input string name);
        @(negedge clk);
        we  = 1'b0;
        en  = 1'b0;
        rst = 1'b1;
        #1;
        check(name, 16'h0000, 1'b0);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // free count
        for (int i = 0; i < 7; i++) set_v(i, 0, 0, 1, 16'h0, 16'(i + 1), 0);
        // after async reset: first enabled edge gives 1
        set_v(7,  0, 0, 1, 16'h0000, 16'h0001, 0);
        // load with en also high: load wins
        set_v(8,  0, 1, 1, 16'h8000, 16'h8000, 0);
        set_v(9,  0, 0, 1, 16'h0000, 16'h8001, 0);
        set_v(10, 0, 0, 1, 16'h0000, 16'h8002, 0);
        set_v(11, 0, 0, 1, 16'h0000, 16'h8003, 0);
        set_v(12, 0, 0, 1, 16'h0000, 16'h8004, 0);
        // wrap
        set_v(13, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
        set_v(14, 0, 0, 1, 16'h0000, 16'h0000, 1);
        set_v(15, 0, 0, 1, 16'h0000, 16'h0001, 0);
        // hold
        set_v(16, 0, 1, 0, 16'h1234, 16'h1234, 0);
        set_v(17, 0, 0, 0, 16'h0000, 16'h1234, 0);
        set_v(18, 0, 0, 0, 16'h0000, 16'h1234, 0);
        set_v(19, 0, 0, 0, 16'h0000, 16'h1234, 0);
        // load of zero over a pending wrap: no overflow
        set_v(20, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
        set_v(21, 0, 1, 1, 16'h0000, 16'h0000, 0);
        // set up a wrap, then reset while overflow is high
        set_v(22, 0, 1, 0, 16'hFFFF, 16'hFFFF, 0);
        set_v(23, 0, 0, 1, 16'h0000, 16'h0000, 1);
        set_v(24, 0, 0, 1, 16'h0000, 16'h0001, 0);
        // reset held across an edge overrides en, then counting resumes
        set_v(25, 1, 0, 1, 16'h0000, 16'h0000, 0);
        set_v(26, 0, 0, 1, 16'h0000, 16'h0001, 0);

        rst  = 1'b1;
        we   = 1'b0;
        en   = 1'b0;
        data = 16'h0;
        #2;
        check("reset_state", 16'h0000, 1'b0);

        run(0, 6);
        async_reset("async_rst_mid_count");
        run(7, 23);
        async_reset("async_rst_during_wrap");
        run(24, 26);

        // overflow must not persist with en low after a wrap
        run(22, 23);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        #1;
        check("ovf_not_sticky", 16'h0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/counter.md
# counter

Free-running, loadable, up-counter with an overflow flag, used as the CPU's general timer/tick source. It increments once per enabled clock, can be parallel-loaded from the data bus, and reports wrap-around with a one-cycle overflow pulse. Reset is asynchronous and clears all state.

## Interface
- `WIDTH`, default 16: counter, data and value width in bits.

- `clk`  in  1  clock, rising-edge active.
- `rst`  in  1  reset; one clock; reset is asynchronous and active-high.
- `en`  in  1  count enable; increments `value` on each rising edge while high.
- `we`  in  1  write enable; loads `data` into the counter on the rising edge.
- `data`  in  WIDTH  parallel load value.
- `value`  out  WIDTH  current count, registered.
- `overflow`  out  1  registered one-cycle pulse on wrap from all-ones to zero.

## Operation
- Priority: `rst` > `we` > `en` > hold.
- `rst` high: `value` = 0, `overflow` = 0, immediately and independent of `clk`; held while `rst` stays high.
- `we` high at an edge: `value` <= `data`, `overflow` <= 0; `en` ignored that cycle. A load never raises `overflow`, including a load of 0.
- `en` high, `we` low: `value` <= `value` + 1, modulo 2^WIDTH. `overflow` <= 1 iff the old `value` was all ones, else 0.
- `en` low, `we` low: `value` holds, `overflow` <= 0.
- `overflow` is never sticky. It is high for exactly the one cycle after the wrapping edge.
- Unsigned arithmetic throughout. No saturation.

## Timing
- All updates occur on the rising edge of `clk`, except reset.
- Latency is one cycle: a load or increment is visible on `value` after the edge that samples it.
- `overflow` becomes valid together with the `value` = 0 produced by the wrap.
- Asserting `rst` mid-operation clears both outputs asynchronously.
- After `rst` deasserts, the first rising edge with `en` = 1 gives `value` = 1.
- Simultaneous `we` and `en`: the load wins and no increment is applied.
- Simultaneous `we` and wrap condition: the load wins and `overflow` = 0.
- Reset values: `value` = 0, `overflow` = 0.

## Structure
- Single module with a single sequential process: an async-reset register for `value` and one for `overflow`.
- No sub-module.
- The default width constant (16) belongs in the shared CPU package, alongside the data-bus width, so that `WIDTH` defaults to it.
- No typedefs are required.

## Test plan
- Free count: reset, then `en` = 1 for 7 rising edges -> `value` = 7, `overflow` = 0 throughout.
- Async reset mid-count: pulse `rst` between edges while `value` = 7 -> `value` = 0 at once, before the next edge; next enabled edge -> 1.
- Load then count: `data` = 0x8000, `we` = 1 (with `en` = 1) for one edge -> `value` = 0x8000 with no increment. Then `we` = 0 for 4 edges -> 0x8001, 0x8002, 0x8003, 0x8004.
- Wrap: load 0xFFFF, one enabled edge -> `value` = 0x0000, `overflow` = 1. Next edge -> `value` = 1, `overflow` = 0.
- Hold and load priority:
  - `en` = 0 for 3 edges at `value` = 0x1234 -> unchanged, `overflow` = 0.
  - With `value` = 0xFFFF, `we` = 1, `en` = 1, `data` = 0x0000 -> `value` = 0, `overflow` = 0.
- Reset during wrap: assert `rst` while `overflow` = 1 -> `overflow` = 0 immediately.
